// File: rtl/ram_bist_pkg.sv
// Shared state encoding, default widths, LFSR constants and the fill pattern
// used by the RAM BIST initiator and its read-back checker.
package ram_bist_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_MULT    = 3;
    localparam int DEF_RD_LAT  = 1;

    // Shared down-counter: drain cycles or the pseudo-random read budget.
    localparam int CNT_W       = 5;
    localparam int LFSR_RD_CNT = 20;

    // x^10 + x^7 + 1 Fibonacci LFSR: feedback from bits 9 and 6.
    localparam logic [9:0] LFSR_SEED = 10'd35;
    localparam logic [9:0] LFSR_TAPS = 10'h240;

    typedef enum logic [2:0] {
        IDLE,
        W_STB,
        W_GAP,
        R_ISS,
        R_DRAIN,
        DONE
    } state_t;

    // Callers truncate the product to DATA_W bits.
    function automatic logic [31:0] exp_data(input logic [31:0] addr, input logic [31:0] mult);
        return addr * mult;
    endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Read-back checker: delays each read tag by RD_LAT cycles to line it up with
// mem_dout, compares against the fill pattern and tracks errors.
module ram_bist_checker
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MULT   = DEF_MULT,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_rd_vld,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_mem_dout,
    output logic [ADDR_W:0]   o_err_count,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic              o_clean_nxt
);

    logic              w_tag_vld;
    logic [ADDR_W-1:0] w_tag_addr;
    logic [DATA_W-1:0] w_exp;
    logic              w_mismatch;
    logic [ADDR_W:0]   r_err_count;
    logic [ADDR_W-1:0] r_fail_addr;

    generate
        if (RD_LAT == 0) begin : g_no_pipe
            assign w_tag_vld  = i_rd_vld;
            assign w_tag_addr = i_rd_addr;
        end else begin : g_pipe
            logic [RD_LAT-1:0] r_vld_sr;
            logic [ADDR_W-1:0] r_addr_sr [RD_LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld_sr <= '0;
                    for (int i = 0; i < RD_LAT; i++) r_addr_sr[i] <= '0;
                end else begin
                    r_vld_sr[0]  <= i_rd_vld;
                    r_addr_sr[0] <= i_rd_addr;
                    for (int i = 1; i < RD_LAT; i++) begin
                        r_vld_sr[i]  <= r_vld_sr[i-1];
                        r_addr_sr[i] <= r_addr_sr[i-1];
                    end
                end
            end

            assign w_tag_vld  = r_vld_sr[RD_LAT-1];
            assign w_tag_addr = r_addr_sr[RD_LAT-1];
        end
    endgenerate

    assign w_exp      = DATA_W'(exp_data(32'(w_tag_addr), 32'(MULT)));
    assign w_mismatch = w_tag_vld && (i_mem_dout != w_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
            r_fail_addr <= '0;
        end else if (i_clear) begin
            r_err_count <= '0;
            r_fail_addr <= '0;
        end else if (w_mismatch) begin
            if (~&r_err_count) r_err_count <= r_err_count + (ADDR_W+1)'(1);
            if (r_err_count == '0) r_fail_addr <= w_tag_addr;
        end
    end

    // Lets the top register pass in the same cycle as the final compare.
    assign o_clean_nxt = (r_err_count == '0) && !w_mismatch;
    assign o_err_count = r_err_count;
    assign o_fail_addr = r_fail_addr;

endmodule

// File: rtl/ram_bist_initiator.sv
// RAM BIST initiator: fills the RAM with addr*MULT, reads it back and reports.
// Define RAM_BIST_LFSR_READ_EN for 20 LFSR-addressed reads instead of a full scan.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// W_STB   | write strobe for addr
// W_GAP   | write idle cycle, advance addr
// R_ISS   | issue one read per cycle
// R_DRAIN | wait RD_LAT cycles for in-flight compares
// DONE    | result valid, start reruns
module ram_bist_initiator
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MULT   = DEF_MULT,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wr,
    output logic              mem_cs,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
`ifdef RAM_BIST_LFSR_READ_EN
    localparam logic [ADDR_W-1:0] RD_FIRST = ADDR_W'(LFSR_SEED);
`else
    localparam logic [ADDR_W-1:0] RD_FIRST = '0;
`endif

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt, w_rd_adv;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              w_start_acc, w_rd_last, w_clean_nxt;

    logic              r_busy, r_done, r_pass, r_mem_wr, r_mem_cs;
    logic              w_busy, w_done, w_pass, w_mem_wr, w_mem_cs;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [DATA_W-1:0] r_mem_din, w_mem_din;

`ifdef RAM_BIST_LFSR_READ_EN
    assign w_rd_last = (r_cnt == '0);
    assign w_rd_adv  = {r_addr[ADDR_W-2:0], ^(r_addr & ADDR_W'(LFSR_TAPS))};
`else
    assign w_rd_last = (r_addr == ADDR_MAX);
    assign w_rd_adv  = r_addr + ADDR_W'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_start_acc = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = W_STB;
                    w_addr_nxt  = '0;
                end
            end
            W_STB: w_state_nxt = W_GAP;
            W_GAP: begin
                if (r_addr == ADDR_MAX) begin
                    w_state_nxt = R_ISS;
                    w_addr_nxt  = RD_FIRST;
                    w_cnt_nxt   = CNT_W'(LFSR_RD_CNT - 1);
                end else begin
                    w_state_nxt = W_STB;
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                end
            end
            R_ISS: begin
                if (w_rd_last) begin
                    if (RD_LAT == 0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = R_DRAIN;
                        w_cnt_nxt   = CNT_W'(RD_LAT - 1);
                    end
                end else begin
                    w_addr_nxt = w_rd_adv;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                end
            end
            R_DRAIN: begin
                if (r_cnt == '0) w_state_nxt = DONE;
                else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_mem_cs   = 1'b0;
        w_mem_wr   = 1'b0;
        w_mem_addr = r_mem_addr;
        w_mem_din  = r_mem_din;
        case (w_state_nxt)
            W_STB: begin
                w_mem_cs   = 1'b1;
                w_mem_wr   = 1'b1;
                w_mem_addr = w_addr_nxt;
                w_mem_din  = DATA_W'(exp_data(32'(w_addr_nxt), 32'(MULT)));
            end
            R_ISS: begin
                w_mem_cs   = 1'b1;
                w_mem_addr = w_addr_nxt;
            end
            default: ;
        endcase
        w_busy = (w_state_nxt != IDLE) && (w_state_nxt != DONE);
        w_done = (w_state_nxt == DONE);
        w_pass = w_done && w_clean_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_mem_cs   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_pass     <= w_pass;
            r_mem_cs   <= w_mem_cs;
            r_mem_wr   <= w_mem_wr;
            r_mem_addr <= w_mem_addr;
            r_mem_din  <= w_mem_din;
        end
    end

    ram_bist_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MULT   (MULT),
        .RD_LAT (RD_LAT)
    ) u_checker (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start_acc),
        .i_rd_vld    (r_mem_cs & ~r_mem_wr),
        .i_rd_addr   (r_mem_addr),
        .i_mem_dout  (mem_dout),
        .o_err_count (err_count),
        .o_fail_addr (fail_addr),
        .o_clean_nxt (w_clean_nxt)
    );

    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign mem_cs   = r_mem_cs;
    assign mem_wr   = r_mem_wr;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;

endmodule

// File: doc/ram_bist_initiator.md
Name: ram_bist_initiator

Overview:
- Initiator side of the 1024x8 single-port RAM interface (addr/data_in/data_out/wr/cs).
- On a start pulse it fills the whole RAM with a deterministic pattern, reads every location back, and compares each word against the expected value.
- Reports pass/fail, an error count and the first failing address.
- Sits between the RAM and a system/test controller; it replaces bench-driven fill/scan with synthesizable RTL.

Parameters:
- ADDR_W, 10, RAM address width; depth N = 2^ADDR_W.
- DATA_W, 8, RAM data width.
- MULT, 3, pattern multiplier; expected data = (addr*MULT) mod 2^DATA_W.
- RD_LAT, 1, cycles from read address/cs to valid mem_dout (range 0..3).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin; sampled only in IDLE or DONE.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  level; high in DONE until the next accepted start or rst.
- pass  out  1  valid while done=1; 1 when err_count==0.
- err_count  out  ADDR_W+1  mismatches seen; saturates at all-ones.
- fail_addr  out  ADDR_W  address of the first mismatch; 0 if none.
- mem_addr  out  ADDR_W  RAM address.
- mem_din  out  DATA_W  write data to the RAM.
- mem_wr  out  1  write enable.
- mem_cs  out  1  chip select.
- mem_dout  in  DATA_W  read data from the RAM.

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs are 0: busy, done, pass, err_count, fail_addr, mem_addr, mem_din, mem_wr, mem_cs.
- All outputs are registered.
- States: IDLE, W_STB, W_GAP, R_ISS, R_DRAIN, DONE.
- IDLE/DONE + start: clear err_count, fail_addr, pass and done; set addr counter=0; go to W_STB.
- W_STB (1 cycle): mem_cs=mem_wr=1, mem_addr=addr, mem_din=(addr*MULT) truncated to DATA_W. Go to W_GAP.
- W_GAP (1 cycle): mem_cs=mem_wr=0, address and data held.
  - If addr==N-1: set addr=0 and go to R_ISS.
  - Otherwise increment addr and go to W_STB.
- R_ISS (one address per cycle): mem_cs=1, mem_wr=0, mem_addr=addr.
  - A valid/address pipeline of depth RD_LAT tags each read.
  - The compare happens in the cycle the tagged entry emerges.
  - addr==N-1 moves to R_DRAIN; with RD_LAT=0 it goes directly to DONE.
- R_DRAIN: mem_cs=0 for RD_LAT cycles while in-flight compares retire, then DONE.
- Compare on mismatch:
  - err_count increments, saturating.
  - fail_addr is captured only when err_count was 0.
- Entering DONE: busy=0, done=1, pass=(err_count==0). The final compare is included.
- Timing: start is sampled at cycle 0; done rises at cycle 3N+RD_LAT+1 (3074 for defaults).
- mem_wr is never high while mem_cs is low. mem_wr and mem_cs are never both high outside W_STB.
- Boundaries:
  - start while busy is ignored.
  - start in DONE restarts the sequence.
  - Address wrap from N-1 ends the phase and never re-writes address 0.
  - rst mid-operation aborts: the RAM interface deasserts in the same instant, and no partial result is reported.

Optional Feature:
- Macro RAM_BIST_LFSR_READ_EN.
- Defined: the read phase issues 20 reads at pseudo-random addresses.
  - Addresses come from an ADDR_W-bit Fibonacci LFSR: taps x^10+x^7+1 for ADDR_W=10, seed 10'd35, advancing once per read.
  - Timing: done rises at cycle 2N+20+RD_LAT+1.
  - Compare and error rules are unchanged.
- Undefined: full sequential scan as above. No LFSR logic is present.

Decomposition:
- Package ram_bist_pkg: state enum, default widths, the LFSR seed/taps constants, and the expected-data function (addr*MULT mod 2^DATA_W).
- One sub-module, ram_bist_checker: RD_LAT pipeline, compare, err_count saturation and fail_addr capture.
- The FSM and address counter stay in the top.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; state IDLE.
- Clean run with a behavioural RAM, RD_LAT=1:
  - start -> write strobes seen with addr 5 data 15 and addr 100 data 44.
  - done at cycle 3074; pass=1, err_count=0.
- Single fault (the model flips bit0 on reads of addr 7, so 21 is returned as 20) -> err_count=1, fail_addr=7, pass=0.
- Faults at addr 3 and addr 1023 -> err_count=2, fail_addr=3. The last-address compare must be counted before done.
- Reset at cycle 500, during the write phase -> mem_cs=mem_wr=0, busy=0, done=0. A following start completes with pass=1 at 3074 cycles.
- Protocol edges: start held during busy has no effect. start while done=1 clears done/pass/err_count next cycle and reruns. With RAM_BIST_LFSR_READ_EN, the first read addr is 35 and done comes at cycle 2070.
